// File: rtl/alu_issue.sv
// Issue front end for the 48-bit ALU: decodes aluop/funct, presents registered
// operands/control to the combinational ALU for one cycle, returns the result.
module alu_issue #(
   parameter int WIDTH = 48,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_aluop,
   input  logic [5:0]         req_funct,
   input  logic [0:WIDTH-1]   req_a,
   input  logic [0:WIDTH-1]   req_b,
   output logic [0:WIDTH-1]   alu_a,
   output logic [0:WIDTH-1]   alu_b,
   output logic [3:0]         alu_control,
   input  logic [0:WIDTH-1]   alu_result,
   input  logic               alu_zero,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [0:WIDTH-1]   rsp_result,
   output logic               rsp_zero,
   output logic               rsp_err,
   output logic [CNT_W-1:0]   ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [0:WIDTH-1]   alu_a_q, alu_a_d;
   logic [0:WIDTH-1]   alu_b_q, alu_b_d;
   logic [3:0]         alu_control_q, alu_control_d;
   logic [0:WIDTH-1]   rsp_result_q, rsp_result_d;
   logic               rsp_zero_q, rsp_zero_d;
   logic               rsp_err_q, rsp_err_d;
   logic [CNT_W-1:0]   ops_done_q, ops_done_d;

   logic               dec_legal;
   logic [3:0]         dec_code;

   always_comb begin
      dec_legal = 1'b1;
      dec_code  = 4'h0;
      unique case (req_aluop)
         2'b00: dec_code = 4'h2;
         2'b01: dec_code = 4'h6;
         2'b10: begin
            unique case (req_funct)
               6'h20:   dec_code = 4'h2;
               6'h22:   dec_code = 4'h6;
               6'h24:   dec_code = 4'h0;
               6'h25:   dec_code = 4'h1;
               6'h2A:   dec_code = 4'h7;
               6'h27:   dec_code = 4'hC;
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Handshake outputs come from state only; reset just masks them.
   assign req_ready = (state_q == IDLE) && !reset;
   assign rsp_valid = (state_q == RESP) && !reset;

   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_control_d = alu_control_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_err_d     = rsp_err_q;
      ops_done_d    = ops_done_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (dec_legal) begin
                  alu_a_d       = req_a;
                  alu_b_d       = req_b;
                  alu_control_d = dec_code;
                  state_d       = EXEC;
               end else begin
                  // Illegal ops skip the ALU entirely and answer with an error.
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b0;
                  rsp_err_d    = 1'b1;
                  state_d      = RESP;
               end
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = 1'b0;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               ops_done_d = ops_done_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_control_q <= 4'h0;
         rsp_result_q  <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_err_q     <= 1'b0;
         ops_done_q    <= '0;
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_control_q <= alu_control_d;
         rsp_result_q  <= rsp_result_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_err_q     <= rsp_err_d;
         ops_done_q    <= ops_done_d;
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_control = alu_control_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_zero    = rsp_zero_q;
   assign rsp_err     = rsp_err_q;
   assign ops_done    = ops_done_q;

endmodule
